syndrome_accumulator: RTL

Streaming BCH syndrome engine directly downstream of the decoder controller. Absorbs 8 received LLR lanes per beat under the controller's write strobes. Accumulates the odd-power syndromes of the hard-decision polynomial by Horner's rule. Presents them, with a zero flag, to the error-locator stage once the last beat of the frame is in.

---
 rtl/syndrome_accumulator_if.sv | 40 ++++
 rtl/syndrome_accumulator.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/syndrome_accumulator_if.sv
// Syndrome accumulator bus.
// Carries the controller-to-accumulator beat stream and the syndrome results
// returned to the error-locator stage.
//   i_code                   : code select, sampled on the first beat of a frame
//   i_data                   : 8 lanes x 8-bit signed LLR, lane 0 in the top byte
//   i_syndrome_clear_and_wen : first beat of a frame
//   i_syndrome_wen           : beat valid
//   o_syndrome               : {S7,S5,S3,S1}, 10 bits each
//   o_syndrome_valid         : syndromes final (level)
//   o_syndrome_zero          : all active syndromes zero, qualified by valid
// master = controller side, slave = accumulator side.
interface syndrome_accumulator_if;
  logic [1:0]  i_code;
  logic [63:0] i_data;
  logic        i_syndrome_clear_and_wen;
  logic        i_syndrome_wen;
  logic [39:0] o_syndrome;
  logic        o_syndrome_valid;
  logic        o_syndrome_zero;

  modport master (
    output i_code,
    output i_data,
    output i_syndrome_clear_and_wen,
    output i_syndrome_wen,
    input  o_syndrome,
    input  o_syndrome_valid,
    input  o_syndrome_zero
  );

  modport slave (
    input  i_code,
    input  i_data,
    input  i_syndrome_clear_and_wen,
    input  i_syndrome_wen,
    output o_syndrome,
    output o_syndrome_valid,
    output o_syndrome_zero
  );
endinterface

// File: rtl/syndrome_accumulator.sv
// Streaming BCH odd-power syndrome engine.
// Takes 8 hard decisions (LLR sign bits) per beat and updates S1,S3 (and S5,S7
// for the 1023-bit code) by Horner's rule, one beat per clock. Once the last
// beat of a frame is absorbed the syndromes and a zero flag are presented,
// qualified by a level valid that is held until the next frame starts.
// Ports:
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   bus     : syndrome_accumulator_if.slave (beat input, syndrome output)
module syndrome_accumulator (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  syndrome_accumulator_if.slave        bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Multiply by alpha in the field chosen by code (0: GF(2^6), 1: GF(2^8),
  // 2: GF(2^10)). Inputs are already reduced to m bits.
  function automatic logic [9:0] mul_alpha(input logic [9:0] x, input logic [1:0] code);
    logic [9:0] r;
    case (code)
      2'd1: begin
        r = {2'b00, x[6:0], 1'b0};
        if (x[7]) r = r ^ 10'h01d;
      end
      2'd2: begin
        r = {x[8:0], 1'b0};
        if (x[9]) r = r ^ 10'h009;
      end
      default: begin
        r = {4'b0000, x[4:0], 1'b0};
        if (x[5]) r = r ^ 10'h003;
      end
    endcase
    return r;
  endfunction

  // acc <- acc*alpha^j + b_k for lanes 0..7, which equals
  // acc*alpha^(8j) + sum_k b_k*alpha^(j(7-k)). j is constant at every call site.
  function automatic logic [9:0] horner(input logic [9:0] acc_in, input logic [7:0] bits,
                                        input logic [1:0] code, input logic [2:0] j);
    logic [9:0] acc;
    acc = acc_in;
    for (int k = 0; k < 8; k++) begin
      for (int t = 0; t < 7; t++) begin
        if (3'(t) < j) acc = mul_alpha(acc, code);
      end
      acc[0] = acc[0] ^ bits[k];
    end
    return acc;
  endfunction

  logic [1:0] state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [1:0] code_q, code_d;
  logic [9:0] s1_q, s1_d, s3_q, s3_d, s5_q, s5_d, s7_q, s7_d;
  logic       valid_q, valid_d;
  logic       zero_q, zero_d;

  logic       start, accept;
  logic [1:0] code_eff;
  logic [7:0] hard;
  logic [6:0] last_cnt;
  logic [9:0] base1, base3, base5, base7;
  logic [55:0] unused_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    s1_d    = s1_q;
    s3_d    = s3_q;
    s5_d    = s5_q;
    s7_d    = s7_q;
    valid_d = valid_q;
    zero_d  = zero_q;

    start  = bus.i_syndrome_clear_and_wen;
    accept = start || (bus.i_syndrome_wen && (state_q == StAcc));

    // Code 3 is folded onto code 0 at sampling time.
    if (start) code_eff = (bus.i_code == 2'd3) ? 2'd0 : bus.i_code;
    else       code_eff = code_q;

    for (int k = 0; k < 8; k++) begin
      hard[k]              = bus.i_data[63 - 8*k];
      unused_mag[7*k +: 7] = bus.i_data[62 - 8*k -: 7];
    end
    // Lane 0 of the first beat is padding above x^(n-1).
    if (start) hard[0] = 1'b0;

    case (code_eff)
      2'd1:    last_cnt = 7'd31;
      2'd2:    last_cnt = 7'd127;
      default: last_cnt = 7'd7;
    endcase

    base1 = start ? 10'd0 : s1_q;
    base3 = start ? 10'd0 : s3_q;
    base5 = start ? 10'd0 : s5_q;
    base7 = start ? 10'd0 : s7_q;

    if (accept) begin
      s1_d = horner(base1, hard, code_eff, 3'd1);
      s3_d = horner(base3, hard, code_eff, 3'd3);
      if (code_eff == 2'd2) begin
        s5_d = horner(base5, hard, code_eff, 3'd5);
        s7_d = horner(base7, hard, code_eff, 3'd7);
      end else begin
        s5_d = 10'd0;
        s7_d = 10'd0;
      end
    end

    if (start) begin
      state_d = StAcc;
      cnt_d   = 7'd1;
      code_d  = code_eff;
      valid_d = 1'b0;
      zero_d  = 1'b0;
    end else if (accept) begin
      cnt_d = cnt_q + 7'd1;
      if (cnt_q == last_cnt) begin
        state_d = StDone;
        valid_d = 1'b1;
        zero_d  = (s1_d == 10'd0) && (s3_d == 10'd0) && (s5_d == 10'd0) && (s7_d == 10'd0);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 7'd0;
      code_q  <= 2'd0;
      s1_q    <= 10'd0;
      s3_q    <= 10'd0;
      s5_q    <= 10'd0;
      s7_q    <= 10'd0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      s1_q    <= s1_d;
      s3_q    <= s3_d;
      s5_q    <= s5_d;
      s7_q    <= s7_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.o_syndrome       = {s7_q, s5_q, s3_q, s1_q};
  assign bus.o_syndrome_valid = valid_q;
  assign bus.o_syndrome_zero  = zero_q;

endmodule
